peak_report_serializer: RTL

Drains per-channel peak reports (128-bit record: peak1, side1, index1, peak2, side2, index2) from a peak-detect channel and serializes them onto a 32-bit AXI-Stream master toward the DMA/host. Each accepted record is buffered in a small FIFO, prefixed with a header beat carrying channel ID and frame sequence number, and emitted as a 5-beat packet with TLAST on the final beat. Sits directly downstream of one peak-detect channel, clocked on the same `clk`.

---
 rtl/peak_report_serializer.sv | 78 +++++++
 1 files changed

// File: rtl/peak_report_serializer.sv
// peak_report_serializer: buffers peak reports in a FIFO and streams each as a 5-beat AXI-Stream packet
module peak_report_serializer #(
  parameter int CHANNEL_ID = 0,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rec_valid,
  input  logic [127:0] rec_data,
  output logic [31:0] m_tdata,
  output logic m_tvalid,
  input  logic m_tready,
  output logic m_tlast,
  output logic [15:0] drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR = 3'd1;
  localparam logic [2:0] B1 = 3'd2;
  localparam logic [2:0] B2 = 3'd3;
  localparam logic [2:0] B3 = 3'd4;
  localparam logic [2:0] B4 = 3'd5;
  logic [143:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0] count_n;
  logic [2:0] state, state_n;
  logic [15:0] seq;
  logic [143:0] nxt_rec;
  logic [31:0] data_n;
  logic hs, pop, push, drop;
  // Next-cycle FIFO bookkeeping, sequencer state and output beat; the head bypasses storage when the FIFO is about to hold only the incoming record
  always_comb begin
    hs = m_tvalid & m_tready;
    pop = hs & (state == B4);
    push = rec_valid & ((fifo_level != CW'(DEPTH)) | pop);
    drop = rec_valid & ~push;
    count_n = fifo_level + CW'(push) - CW'(pop);
    rd_ptr_n = rd_ptr + AW'(pop);
    nxt_rec = (fifo_level == CW'(pop)) ? {seq, rec_data} : mem[rd_ptr_n];
    state_n = (state == IDLE || (hs && state == B4)) ? ((count_n != '0) ? HDR : IDLE) :
              hs ? state + 3'd1 : state;
    data_n = (state_n == HDR) ? {8'h5A, 8'(CHANNEL_ID), nxt_rec[143:128]} :
             (state_n == B1) ? nxt_rec[127:96] :
             (state_n == B2) ? nxt_rec[95:64] :
             (state_n == B3) ? nxt_rec[63:32] :
             (state_n == B4) ? nxt_rec[31:0] : 32'd0;
  end
  // Record storage; the in-flight head is never the write target because a full FIFO only accepts alongside a pop
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= {seq, rec_data};
  end
  // Sequencer, registered stream outputs, pointers and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      m_tvalid <= 1'b0;
      m_tlast <= 1'b0;
      m_tdata <= 32'd0;
      drop_count <= 16'd0;
      fifo_level <= '0;
      seq <= 16'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_n;
      m_tvalid <= state_n != IDLE;
      m_tlast <= state_n == B4;
      m_tdata <= data_n;
      fifo_level <= count_n;
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr + AW'(push);
      if (rec_valid) seq <= seq + 16'd1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
endmodule
